// File: rtl/uart_rx_multi_if.sv
// ---------------------------------------------------------------------------
// uart_rx_multi_if
// Output bundle of the multi-format UART receiver: the word-valid strobe,
// the received word, both error flags and the busy indication.
//
// Parameters
//   DATA_BITS    width of the received word (5..9)
//
// Signals
//   o_Rx_DV      one-cycle strobe: word and error flags are valid
//   o_Rx_Word    received word, held until the next strobe
//   o_Frame_Err  a stop-bit sample was 0 (held until the next strobe)
//   o_Parity_Err parity mismatch (held until the next strobe)
//   o_Busy       receiver is inside a frame (FSM not idle)
//
// Modports
//   master       receiver side, drives every signal
//   slave        consumer side (byte/command parser), reads every signal
// ---------------------------------------------------------------------------
interface uart_rx_multi_if #(
    parameter int DATA_BITS = 8
);
    logic                 o_Rx_DV;
    logic [DATA_BITS-1:0] o_Rx_Word;
    logic                 o_Frame_Err;
    logic                 o_Parity_Err;
    logic                 o_Busy;

    modport master (
        output o_Rx_DV,
        output o_Rx_Word,
        output o_Frame_Err,
        output o_Parity_Err,
        output o_Busy
    );

    modport slave (
        input o_Rx_DV,
        input o_Rx_Word,
        input o_Frame_Err,
        input o_Parity_Err,
        input o_Busy
    );
endinterface

// File: rtl/uart_rx_multi.sv
// ---------------------------------------------------------------------------
// uart_rx_multi
// Parametrised UART receiver: 5..9 data bits (LSB first), 1 or 2 stop bits,
// optional parity. Each received word is reported with a one-cycle strobe
// together with framing and parity error flags.
//
// Optional feature: define UART_RX_PARITY_EN to add one parity bit after the
// data bits. Without it the frame is start + DATA_BITS + STOP_BITS, the
// parity error flag is tied to 0 and i_Parity_Odd is ignored.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per bit (Fclk/baud), >= 4
//   DATA_BITS     data bits per frame, 5..9
//   STOP_BITS     stop bits per frame, 1 or 2
//   SYNC_STAGES   input synchroniser depth, >= 2
//
// Ports
//   i_Clock       single clock, all logic on posedge
//   i_Rst_L       synchronous active-low reset
//   i_Rx_Serial   asynchronous serial line, idle high
//   i_Parity_Odd  1 = odd parity, 0 = even (parity build only)
//   rx_bus        master side of uart_rx_multi_if (strobe, word, flags, busy)
// ---------------------------------------------------------------------------
module uart_rx_multi #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic            i_Clock,
    input  logic            i_Rst_L,
    input  logic            i_Rx_Serial,
    input  logic            i_Parity_Odd,
    uart_rx_multi_if.master rx_bus
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID_CNT   = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE,
        WAIT_HIGH
    } state_t;

    // Input synchroniser; resets to the idle (high) line level
    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s;

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], i_Rx_Serial};
        end
    end

    assign rx_s = sync[SYNC_STAGES-1];

    // FSM and datapath state
    state_t               state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [IW-1:0]        idx, idx_nxt;
    logic                 stop_idx, stop_idx_nxt;
    logic [DATA_BITS-1:0] shift, shift_nxt;
    logic                 frame_acc, frame_acc_nxt;
    logic                 rx_dv, rx_dv_nxt;
    logic [DATA_BITS-1:0] word, word_nxt;
    logic                 frame_err, frame_err_nxt;
`ifdef UART_RX_PARITY_EN
    logic                 parity_acc, parity_acc_nxt;
    logic                 parity_err, parity_err_nxt;
`else
    logic                 unused_parity_odd;
    assign unused_parity_odd = i_Parity_Odd;
`endif

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            stop_idx  <= 1'b0;
            frame_acc <= 1'b0;
            rx_dv     <= 1'b0;
            word      <= '0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_acc <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            stop_idx  <= stop_idx_nxt;
            frame_acc <= frame_acc_nxt;
            rx_dv     <= rx_dv_nxt;
            word      <= word_nxt;
            frame_err <= frame_err_nxt;
`ifdef UART_RX_PARITY_EN
            parity_acc <= parity_acc_nxt;
            parity_err <= parity_err_nxt;
`endif
        end
    end

    // The shift register is pure data: every bit is rewritten before use
    always_ff @(posedge i_Clock) begin
        shift <= shift_nxt;
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        idx_nxt       = idx;
        stop_idx_nxt  = stop_idx;
        shift_nxt     = shift;
        frame_acc_nxt = frame_acc;
        rx_dv_nxt     = 1'b0;
        word_nxt      = word;
        frame_err_nxt = frame_err;
`ifdef UART_RX_PARITY_EN
        parity_acc_nxt = parity_acc;
        parity_err_nxt = parity_err;
`endif

        unique case (state)
            IDLE: begin
                cnt_nxt       = '0;
                idx_nxt       = '0;
                stop_idx_nxt  = 1'b0;
                frame_acc_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_acc_nxt = 1'b0;
`endif
                if (!rx_s) begin
                    state_nxt = START;
                end
            end

            // Re-check the start bit at its middle to reject glitches
            START: begin
                if (cnt == MID_CNT) begin
                    cnt_nxt   = '0;
                    state_nxt = rx_s ? IDLE : DATA;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            // Sampling one full bit after the start mid-point lands mid-bit
            DATA: begin
                if (cnt == LAST_CNT) begin
                    cnt_nxt        = '0;
                    shift_nxt[idx] = rx_s;
                    if (idx == LAST_IDX) begin
                        idx_nxt = '0;
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end else begin
                        idx_nxt = idx + IW'(1);
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == LAST_CNT) begin
                    cnt_nxt        = '0;
                    parity_acc_nxt = ((^shift) ^ rx_s) != i_Parity_Odd;
                    state_nxt      = STOP;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
`endif

            // The last stop sample loads the outputs so they appear in DONE
            STOP: begin
                if (cnt == LAST_CNT) begin
                    cnt_nxt = '0;
                    if (!rx_s) begin
                        frame_acc_nxt = 1'b1;
                    end
                    if (stop_idx == LAST_STOP) begin
                        state_nxt     = DONE;
                        rx_dv_nxt     = 1'b1;
                        word_nxt      = shift;
                        frame_err_nxt = frame_acc | ~rx_s;
`ifdef UART_RX_PARITY_EN
                        parity_err_nxt = parity_acc;
`endif
                    end else begin
                        stop_idx_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            // A bad stop bit may mean a break: wait for the line to recover
            DONE: begin
                state_nxt = frame_err ? WAIT_HIGH : IDLE;
            end

            WAIT_HIGH: begin
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign rx_bus.o_Rx_DV     = rx_dv;
    assign rx_bus.o_Rx_Word   = word;
    assign rx_bus.o_Frame_Err = frame_err;
`ifdef UART_RX_PARITY_EN
    assign rx_bus.o_Parity_Err = parity_err;
`else
    assign rx_bus.o_Parity_Err = 1'b0;
`endif
    assign rx_bus.o_Busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_multi.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_multi
// Three receivers share clock and reset: 8N1, 9-bit/1-stop and 7-bit/2-stop.
// Each has its own serial line driven by a bit-level transmitter task and a
// scoreboard queue of expected {word, frame error, parity error} records that
// is popped whenever the receiver strobes o_Rx_DV.
// ---------------------------------------------------------------------------
module tb_uart_rx_multi;

    localparam int CPB = 16;

`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct {
        logic [8:0] word;
        logic       ferr;
        logic       perr;
    } exp_t;

    typedef struct {
        logic [8:0] data;
        logic [8:0] exp_word;
        logic       exp_ferr;
    } vec_t;

    logic clk;
    logic rst_l;
    logic rx8, rx9, rx7;
    logic parity_odd;

    int checks;
    int failures;
    int dv_cnt8, dv_cnt9, dv_cnt7;

    exp_t sb8[$];
    exp_t sb9[$];
    exp_t sb7[$];

    uart_rx_multi_if #(.DATA_BITS(8)) bus8 ();
    uart_rx_multi_if #(.DATA_BITS(9)) bus9 ();
    uart_rx_multi_if #(.DATA_BITS(7)) bus7 ();

    uart_rx_multi #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .SYNC_STAGES(2)) u_dut8 (
        .i_Clock(clk), .i_Rst_L(rst_l), .i_Rx_Serial(rx8), .i_Parity_Odd(parity_odd), .rx_bus(bus8)
    );
    uart_rx_multi #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .STOP_BITS(1), .SYNC_STAGES(2)) u_dut9 (
        .i_Clock(clk), .i_Rst_L(rst_l), .i_Rx_Serial(rx9), .i_Parity_Odd(parity_odd), .rx_bus(bus9)
    );
    uart_rx_multi #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2), .SYNC_STAGES(2)) u_dut7 (
        .i_Clock(clk), .i_Rst_L(rst_l), .i_Rx_Serial(rx7), .i_Parity_Odd(parity_odd), .rx_bus(bus7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic par_of(input logic [8:0] d, input int n);
        logic p;
        p = 1'b0;
        for (int i = 0; i < n; i++) p = p ^ d[i];
        return p;
    endfunction

    task automatic set_line(input int which, input logic v);
        case (which)
            8:       rx8 = v;
            9:       rx9 = v;
            default: rx7 = v;
        endcase
    endtask

    task automatic hold_bit(input int which, input logic v, input int cycles);
        set_line(which, v);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // start, data LSB first, optional parity, stop bits, optional low hold
    task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                              input int nstop, input logic par, input logic [1:0] stop_bits,
                              input int hold_low);
        hold_bit(which, 1'b0, CPB);
        for (int i = 0; i < nbits; i++) hold_bit(which, data[i], CPB);
        if (PAR) hold_bit(which, par, CPB);
        for (int s = 0; s < nstop; s++) hold_bit(which, stop_bits[s], CPB);
        if (hold_low > 0) hold_bit(which, 1'b0, hold_low);
        set_line(which, 1'b1);
    endtask

    task automatic push8(input logic [8:0] w, input logic f, input logic p);
        exp_t e;
        e.word = w; e.ferr = f; e.perr = p;
        sb8.push_back(e);
    endtask

    task automatic push9(input logic [8:0] w, input logic f, input logic p);
        exp_t e;
        e.word = w; e.ferr = f; e.perr = p;
        sb9.push_back(e);
    endtask

    task automatic push7(input logic [8:0] w, input logic f, input logic p);
        exp_t e;
        e.word = w; e.ferr = f; e.perr = p;
        sb7.push_back(e);
    endtask

    always @(negedge clk) begin : mon8
        exp_t e;
        if (bus8.o_Rx_DV === 1'b1) begin
            dv_cnt8++;
            if (sb8.size() == 0) begin
                checks++; failures++;
                $display("FAIL dut8_unexpected_strobe actual=word 0x%0h required=no strobe", bus8.o_Rx_Word);
            end else begin
                e = sb8.pop_front();
                chk("dut8_word", 32'(bus8.o_Rx_Word), 32'(e.word));
                chk("dut8_frame_err", 32'(bus8.o_Frame_Err), 32'(e.ferr));
                chk("dut8_parity_err", 32'(bus8.o_Parity_Err), 32'(e.perr));
            end
        end
    end

    always @(negedge clk) begin : mon9
        exp_t e;
        if (bus9.o_Rx_DV === 1'b1) begin
            dv_cnt9++;
            if (sb9.size() == 0) begin
                checks++; failures++;
                $display("FAIL dut9_unexpected_strobe actual=word 0x%0h required=no strobe", bus9.o_Rx_Word);
            end else begin
                e = sb9.pop_front();
                chk("dut9_word", 32'(bus9.o_Rx_Word), 32'(e.word));
                chk("dut9_frame_err", 32'(bus9.o_Frame_Err), 32'(e.ferr));
                chk("dut9_parity_err", 32'(bus9.o_Parity_Err), 32'(e.perr));
            end
        end
    end

    always @(negedge clk) begin : mon7
        exp_t e;
        if (bus7.o_Rx_DV === 1'b1) begin
            dv_cnt7++;
            if (sb7.size() == 0) begin
                checks++; failures++;
                $display("FAIL dut7_unexpected_strobe actual=word 0x%0h required=no strobe", bus7.o_Rx_Word);
            end else begin
                e = sb7.pop_front();
                chk("dut7_word", 32'(bus7.o_Rx_Word), 32'(e.word));
                chk("dut7_frame_err", 32'(bus7.o_Frame_Err), 32'(e.ferr));
                chk("dut7_parity_err", 32'(bus7.o_Parity_Err), 32'(e.perr));
            end
        end
    end

    initial begin
        vec_t vecs[5];
        int   dv_before;
        int   n;
        bit   seen;

        vecs[0] = '{data: 9'h0A5, exp_word: 9'h0A5, exp_ferr: 1'b0};
        vecs[1] = '{data: 9'h03C, exp_word: 9'h03C, exp_ferr: 1'b0};
        vecs[2] = '{data: 9'h000, exp_word: 9'h000, exp_ferr: 1'b0};
        vecs[3] = '{data: 9'h0FF, exp_word: 9'h0FF, exp_ferr: 1'b0};
        vecs[4] = '{data: 9'h081, exp_word: 9'h081, exp_ferr: 1'b0};

        checks = 0; failures = 0;
        dv_cnt8 = 0; dv_cnt9 = 0; dv_cnt7 = 0;
        rst_l = 1'b0; rx8 = 1'b1; rx9 = 1'b1; rx7 = 1'b1; parity_odd = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_dv", 32'(bus8.o_Rx_DV), 32'd0);
        chk("reset_word", 32'(bus8.o_Rx_Word), 32'd0);
        chk("reset_frame_err", 32'(bus8.o_Frame_Err), 32'd0);
        chk("reset_parity_err", 32'(bus8.o_Parity_Err), 32'd0);
        chk("reset_busy", 32'(bus8.o_Busy), 32'd0);
        chk("reset_busy9", 32'(bus9.o_Busy), 32'd0);
        @(posedge clk); #1 rst_l = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Back-to-back 8N1 frames from the table, no idle gap between them
        for (int v = 0; v < 5; v++) begin
            push8(vecs[v].exp_word, vecs[v].exp_ferr, 1'b0);
            send_frame(8, vecs[v].data, 8, 1, par_of(vecs[v].data, 8), 2'b11, 0);
        end
        hold_bit(8, 1'b1, 2 * CPB);
        chk("table_strobe_count", 32'(dv_cnt8), 32'd5);

        // Short low glitch: busy rises then falls, no strobe
        dv_before = dv_cnt8;
        hold_bit(8, 1'b0, 5);
        set_line(8, 1'b1);
        seen = 1'b0; n = 0;
        while (n < 30 && !(seen && bus8.o_Busy == 1'b0)) begin
            @(negedge clk);
            if (bus8.o_Busy) seen = 1'b1;
            n++;
        end
        chk("glitch_busy_seen", 32'(seen), 32'd1);
        chk("glitch_busy_dropped", 32'(n < 30), 32'd1);
        repeat (2 * CPB) @(posedge clk);
        #1;
        chk("glitch_no_strobe", 32'(dv_cnt8), 32'(dv_before));

        // Stop bit low and line held low as a break: exactly one errored word
        dv_before = dv_cnt8;
        push8(9'h055, 1'b1, 1'b0);
        send_frame(8, 9'h055, 8, 1, par_of(9'h055, 8), 2'b00, 40 * CPB);
        hold_bit(8, 1'b1, 2 * CPB);
        chk("break_single_strobe", 32'(dv_cnt8), 32'(dv_before + 1));
        chk("break_word_held", 32'(bus8.o_Rx_Word), 32'h55);
        chk("break_frame_err_held", 32'(bus8.o_Frame_Err), 32'd1);
        push8(9'h012, 1'b0, 1'b0);
        send_frame(8, 9'h012, 8, 1, par_of(9'h012, 8), 2'b11, 0);
        hold_bit(8, 1'b1, 2 * CPB);

        // Nine data bits
        push9(9'h1FF, 1'b0, 1'b0);
        send_frame(9, 9'h1FF, 9, 1, par_of(9'h1FF, 9), 2'b11, 0);
        push9(9'h100, 1'b0, 1'b0);
        send_frame(9, 9'h100, 9, 1, par_of(9'h100, 9), 2'b11, 0);
        hold_bit(9, 1'b1, 2 * CPB);

        // Seven data bits, two stop bits; parity bit only exists in the parity build
        push7(9'h041, 1'b0, 1'b0);
        send_frame(7, 9'h041, 7, 2, 1'b0, 2'b11, 0);
        push7(9'h041, 1'b0, PAR);
        send_frame(7, 9'h041, 7, 2, 1'b1, 2'b11, 0);
        push7(9'h02A, 1'b1, 1'b0);
        send_frame(7, 9'h02A, 7, 2, par_of(9'h02A, 7), 2'b01, 0);
        hold_bit(7, 1'b1, 2 * CPB);
        push7(9'h07F, 1'b0, 1'b0);
        send_frame(7, 9'h07F, 7, 2, par_of(9'h07F, 7), 2'b11, 0);
        hold_bit(7, 1'b1, 2 * CPB);

        // Reset pulse during data bit 3 of 0xF8 (bits 3..7 high, so no false start)
        dv_before = dv_cnt8;
        fork
            send_frame(8, 9'h0F8, 8, 1, par_of(9'h0F8, 8), 2'b11, 0);
            begin
                repeat (4 * CPB + CPB / 2) @(posedge clk);
                #1 rst_l = 1'b0;
                @(posedge clk);
                #1 rst_l = 1'b1;
                @(negedge clk);
                chk("midreset_dv", 32'(bus8.o_Rx_DV), 32'd0);
                chk("midreset_word", 32'(bus8.o_Rx_Word), 32'd0);
                chk("midreset_frame_err", 32'(bus8.o_Frame_Err), 32'd0);
                chk("midreset_busy", 32'(bus8.o_Busy), 32'd0);
                chk("midreset_word9", 32'(bus9.o_Rx_Word), 32'd0);
            end
        join
        hold_bit(8, 1'b1, 2 * CPB);
        chk("midreset_no_strobe", 32'(dv_cnt8), 32'(dv_before));
        push8(9'h0C3, 1'b0, 1'b0);
        send_frame(8, 9'h0C3, 8, 1, par_of(9'h0C3, 8), 2'b11, 0);

        repeat (3 * CPB) @(posedge clk);
        @(negedge clk);
        chk("final_word_held", 32'(bus8.o_Rx_Word), 32'hC3);
        chk("final_busy8", 32'(bus8.o_Busy), 32'd0);
        chk("sb8_drained", 32'(sb8.size()), 32'd0);
        chk("sb9_drained", 32'(sb9.size()), 32'd0);
        chk("sb7_drained", 32'(sb7.size()), 32'd0);
        chk("dut9_strobe_count", 32'(dv_cnt9), 32'd2);
        chk("dut7_strobe_count", 32'(dv_cnt7), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
